// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, line/frame counters, PIPE-aligned
// sync/blank delay line, colour return register and a colour-bar bring-up pattern.
module vga_timing_gen #(
  parameter int CLK_PER_PIX = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int COLOR_W     = 3,
  parameter int PIPE        = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               pattern_en,
  input  logic [COLOR_W-1:0] r_val,
  input  logic [COLOR_W-1:0] g_val,
  input  logic [COLOR_W-1:0] b_val,
  output logic [10:0]        pix_x,
  output logic [10:0]        pix_y,
  output logic               pix_req,
  output logic               line_start,
  output logic               frame_start,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_H_SYNC,
  output logic               VGA_V_SYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CE_W    = (CLK_PER_PIX > 1) ? $clog2(CLK_PER_PIX) : 1;

  localparam logic [CE_W-1:0] CE_LAST  = CE_W'(CLK_PER_PIX - 1);
  localparam logic [10:0]     H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]     V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]     H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]     V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]     HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]     HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]     VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]     VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0]     BAR_LAST = 11'(H_ACTIVE / 8 - 1);

  logic [CE_W-1:0] ce_cnt_q, ce_cnt_d;
  logic [10:0]     h_cnt_q, h_cnt_d;
  logic [10:0]     v_cnt_q, v_cnt_d;
  logic [10:0]     bar_px_q, bar_px_d;
  logic [2:0]      bar_q, bar_d;

  logic pix_adv, h_wrap, first_clk, active, hs_on, vs_on, frame_pt;

  logic [10:0] pix_x_q, pix_y_q;
  logic        pix_req_q, line_start_q, frame_start_q;
  logic        pat_sel_q;

  logic [PIPE-1:0]      act_dly_q;
  logic [PIPE-1:0]      req_dly_q;
  logic [PIPE-1:0][2:0] bar_dly_q;
  logic [PIPE:0]        hs_dly_q;
  logic [PIPE:0]        vs_dly_q;

  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] samp_r, samp_g, samp_b;
  logic [2:0]         bar_out;

  // Counters describe the pixel whose strobes are registered at the coming edge,
  // so the outputs run one clock behind them.
  always_comb begin
    pix_adv   = (ce_cnt_q == CE_LAST);
    h_wrap    = pix_adv && (h_cnt_q == H_LAST);
    first_clk = (ce_cnt_q == '0);
    active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_on     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
    vs_on     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
    frame_pt  = first_clk && (h_cnt_q == '0) && (v_cnt_q == '0);

    ce_cnt_d = pix_adv ? '0 : ce_cnt_q + CE_W'(1);
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    bar_px_d = bar_px_q;
    bar_d    = bar_q;

    if (pix_adv) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
      if (h_wrap) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end
    end

    // Bar index tracks h_cnt: pixels-within-bar counter instead of a divider.
    if (pix_adv) begin
      if (h_wrap) begin
        bar_px_d = '0;
        bar_d    = '0;
      end else if (h_cnt_q < H_ACT) begin
        if (bar_px_q == BAR_LAST) begin
          bar_px_d = '0;
          bar_d    = bar_q + 3'd1;
        end else begin
          bar_px_d = bar_px_q + 11'd1;
        end
      end
    end
  end

  always_comb begin
    bar_out = bar_dly_q[PIPE-1];
    if (pat_sel_q) begin
      samp_r = {COLOR_W{bar_out[2]}};
      samp_g = {COLOR_W{bar_out[1]}};
      samp_b = {COLOR_W{bar_out[0]}};
    end else begin
      samp_r = r_val;
      samp_g = g_val;
      samp_b = b_val;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ce_cnt_q      <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      bar_px_q      <= '0;
      bar_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_req_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pat_sel_q     <= 1'b0;
      act_dly_q     <= '0;
      req_dly_q     <= '0;
      bar_dly_q     <= '0;
      hs_dly_q      <= '0;
      vs_dly_q      <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      bar_px_q <= bar_px_d;
      bar_q    <= bar_d;

      pix_req_q     <= active && first_clk;
      line_start_q  <= first_clk && (h_cnt_q == '0);
      frame_start_q <= frame_pt;
      if (active) begin
        pix_x_q <= h_cnt_q;
        pix_y_q <= v_cnt_q;
      end
      // Latched at the frame's first edge so it is settled before pixel 0 is sampled.
      if (frame_pt) pat_sel_q <= pattern_en;

      act_dly_q[0] <= active;
      req_dly_q[0] <= active && first_clk;
      bar_dly_q[0] <= bar_q;
      hs_dly_q[0]  <= hs_on;
      vs_dly_q[0]  <= vs_on;
      for (int k = 1; k < PIPE; k++) begin
        act_dly_q[k] <= act_dly_q[k-1];
        req_dly_q[k] <= req_dly_q[k-1];
        bar_dly_q[k] <= bar_dly_q[k-1];
      end
      for (int k = 1; k <= PIPE; k++) begin
        hs_dly_q[k] <= hs_dly_q[k-1];
        vs_dly_q[k] <= vs_dly_q[k-1];
      end

      // This edge is PIPE clocks after the pixel's pix_req edge.
      if (!act_dly_q[PIPE-1]) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end else if (req_dly_q[PIPE-1]) begin
        r_q <= samp_r;
        g_q <= samp_g;
        b_q <= samp_b;
      end
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_req     = pix_req_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_H_SYNC  = (SYNC_POL != 0) ? hs_dly_q[PIPE] : ~hs_dly_q[PIPE];
  assign VGA_V_SYNC  = (SYNC_POL != 0) ? vs_dly_q[PIPE] : ~vs_dly_q[PIPE];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 line timing, a small mode for frame/latency/pattern
// and reset cases, and an 800x600-style CLK_PER_PIX=1 active-high sweep.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int t_b      = 0;

  // DUT A: default parameters
  logic rst_a, pat_a;
  logic [2:0] r_a, g_a, b_a, vr_a, vg_a, vb_a;
  logic [10:0] px_a, py_a;
  logic req_a, ls_a, fs_a, hs_a, vs_a;

  vga_timing_gen u_a (
    .CLOCK_50(clk), .reset(rst_a), .pattern_en(pat_a),
    .r_val(r_a), .g_val(g_a), .b_val(b_a),
    .pix_x(px_a), .pix_y(py_a), .pix_req(req_a), .line_start(ls_a), .frame_start(fs_a),
    .VGA_R(vr_a), .VGA_G(vg_a), .VGA_B(vb_a), .VGA_H_SYNC(hs_a), .VGA_V_SYNC(vs_a)
  );

  // DUT B: 16x6 active, 24x10 total, PIPE=3
  logic rst_b, pat_b;
  logic [2:0] r_b, g_b, b_b, vr_b, vg_b, vb_b;
  logic [10:0] px_b, py_b;
  logic req_b, ls_b, fs_b, hs_b, vs_b;
  logic [10:0] rq1 = '0, rq2 = '0;

  vga_timing_gen #(
    .CLK_PER_PIX(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(0), .COLOR_W(3), .PIPE(3)
  ) u_b (
    .CLOCK_50(clk), .reset(rst_b), .pattern_en(pat_b),
    .r_val(r_b), .g_val(g_b), .b_val(b_b),
    .pix_x(px_b), .pix_y(py_b), .pix_req(req_b), .line_start(ls_b), .frame_start(fs_b),
    .VGA_R(vr_b), .VGA_G(vg_b), .VGA_B(vb_b), .VGA_H_SYNC(hs_b), .VGA_V_SYNC(vs_b)
  );

  // Requester for B: returns pix_x[2:0] so it is valid at the edge 3 clocks after pix_req
  always @(posedge clk) begin
    rq1 <= px_b;
    rq2 <= rq1;
  end
  assign r_b = rq2[2:0];

  // DUT C: CLK_PER_PIX=1, active-high syncs, 800-wide timing, short vertical
  logic rst_c, pat_c;
  logic [2:0] r_c, g_c, b_c, vr_c, vg_c, vb_c;
  logic [10:0] px_c, py_c;
  logic req_c, ls_c, fs_c, hs_c, vs_c;

  vga_timing_gen #(
    .CLK_PER_PIX(1), .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(4), .V_BP(23), .SYNC_POL(1), .COLOR_W(3), .PIPE(2)
  ) u_c (
    .CLOCK_50(clk), .reset(rst_c), .pattern_en(pat_c),
    .r_val(r_c), .g_val(g_c), .b_val(b_c),
    .pix_x(px_c), .pix_y(py_c), .pix_req(req_c), .line_start(ls_c), .frame_start(fs_c),
    .VGA_R(vr_c), .VGA_G(vg_c), .VGA_B(vb_c), .VGA_H_SYNC(hs_c), .VGA_V_SYNC(vs_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_b();
    rst_b = 1'b1;
    repeat (5) tick();
    rst_b = 1'b0;
    tick();
    t_b = 0;
  endtask

  task automatic wait_b(input int n);
    while (t_b < n) begin
      tick();
      t_b++;
    end
  endtask

  // Expected VGA_R of DUT B: pixel x shows x[2:0] from 3 clocks after its pix_req, 2 clocks each
  function automatic logic [2:0] exp_r_b(input int t);
    int u;
    u = t % 48;
    if (u >= 3 && u < 35) return 3'((u - 3) / 2);
    return 3'd0;
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    repeat (5) tick();
    n_checks++; if (hs_a !== 1'b1) $display("FAIL rst_hsync: got %b want 1", hs_a); else n_pass++;
    n_checks++; if (vs_a !== 1'b1) $display("FAIL rst_vsync: got %b want 1", vs_a); else n_pass++;
    n_checks++; if ({vr_a, vg_a, vb_a} !== 9'd0) $display("FAIL rst_colour: got %h want 0", {vr_a, vg_a, vb_a}); else n_pass++;
    n_checks++; if ({req_a, ls_a, fs_a} !== 3'b000) $display("FAIL rst_strobes: got %b want 000", {req_a, ls_a, fs_a}); else n_pass++;
    n_checks++; if ({px_a, py_a} !== 22'd0) $display("FAIL rst_coord: got %0d,%0d want 0,0", px_a, py_a); else n_pass++;
    rst_a = 1'b0;
    tick();
    n_checks++; if ({req_a, ls_a, fs_a} !== 3'b111) $display("FAIL first_strobes: got %b want 111", {req_a, ls_a, fs_a}); else n_pass++;
    n_checks++; if ({px_a, py_a} !== 22'd0) $display("FAIL first_coord: got %0d,%0d want 0,0", px_a, py_a); else n_pass++;
  endtask

  task automatic test_default_line();
    int hf1 = -1, hr1 = -1, hf2 = -1, ls2 = -1, reqs = 1;
    logic prev_hs;
    prev_hs = hs_a;
    for (int t = 1; t <= 2920; t++) begin
      tick();
      if (t < 1600 && req_a) reqs++;
      if (ls_a && ls2 < 0) ls2 = t;
      if (prev_hs && !hs_a) begin
        if (hf1 < 0) hf1 = t;
        else if (hf2 < 0) hf2 = t;
      end
      if (!prev_hs && hs_a && hr1 < 0) hr1 = t;
      prev_hs = hs_a;
      if (t == 1) begin
        n_checks++; if (vr_a !== 3'd0) $display("FAIL a_colour_early: got %0d want 0", vr_a); else n_pass++;
        n_checks++; if (req_a !== 1'b0) $display("FAIL a_req_second_clk: got %b want 0", req_a); else n_pass++;
      end
      if (t == 2) begin
        n_checks++; if ({vr_a, vg_a, vb_a} !== {3'd5, 3'd2, 3'd1}) $display("FAIL a_colour_lat: got %h want %h", {vr_a, vg_a, vb_a}, {3'd5, 3'd2, 3'd1}); else n_pass++;
        n_checks++; if (px_a !== 11'd1) $display("FAIL a_px1: got %0d want 1", px_a); else n_pass++;
      end
      if (t == 1281) begin
        n_checks++; if (vr_a !== 3'd5) $display("FAIL a_last_colour: got %0d want 5", vr_a); else n_pass++;
      end
      if (t == 1282) begin
        n_checks++; if (vr_a !== 3'd0) $display("FAIL a_blank_colour: got %0d want 0", vr_a); else n_pass++;
      end
      if (t == 1599) begin
        n_checks++; if (px_a !== 11'd639) $display("FAIL a_px_freeze: got %0d want 639", px_a); else n_pass++;
      end
      if (t == 1600) begin
        n_checks++; if ({px_a, py_a} !== {11'd0, 11'd1}) $display("FAIL a_line2_coord: got %0d,%0d want 0,1", px_a, py_a); else n_pass++;
      end
    end
    n_checks++; if (hf1 !== 1314) $display("FAIL a_hsync_start: got %0d want 1314", hf1); else n_pass++;
    n_checks++; if (hr1 - hf1 !== 192) $display("FAIL a_hsync_width: got %0d want 192", hr1 - hf1); else n_pass++;
    n_checks++; if (hf2 - hf1 !== 1600) $display("FAIL a_hsync_period: got %0d want 1600", hf2 - hf1); else n_pass++;
    n_checks++; if (ls2 !== 1600) $display("FAIL a_line_period: got %0d want 1600", ls2); else n_pass++;
    n_checks++; if (reqs !== 640) $display("FAIL a_req_per_line: got %0d want 640", reqs); else n_pass++;
    n_checks++; if (vs_a !== 1'b1) $display("FAIL a_vsync_idle: got %b want 1", vs_a); else n_pass++;
  endtask

  task automatic test_latency();
    release_b();
    for (int t = 0; t < 100; t++) begin
      wait_b(t);
      n_checks++;
      if (vr_b !== exp_r_b(t)) $display("FAIL b_latency t=%0d: got %0d want %0d", t, vr_b, exp_r_b(t));
      else n_pass++;
    end
  endtask

  task automatic test_frame_small();
    int vf = -1, vr = -1, hf = -1, hr = -1, fs2 = -1, reqs = 0, lss = 0;
    logic prev_vs, prev_hs;
    rst_b = 1'b1;
    repeat (5) tick();
    rst_b = 1'b0;
    prev_vs = 1'b1;
    prev_hs = 1'b1;
    for (int t = 0; t <= 600; t++) begin
      tick();
      if (t < 480 && req_b) reqs++;
      if (t < 480 && ls_b) lss++;
      if (t > 0 && fs_b && fs2 < 0) fs2 = t;
      if (prev_vs && !vs_b && vf < 0) vf = t;
      if (!prev_vs && vs_b && vr < 0) vr = t;
      if (prev_hs && !hs_b && hf < 0) hf = t;
      if (!prev_hs && hs_b && hr < 0) hr = t;
      prev_vs = vs_b;
      prev_hs = hs_b;
      if (t == 479) begin
        n_checks++; if ({px_b, py_b} !== {11'd15, 11'd5}) $display("FAIL b_coord_freeze: got %0d,%0d want 15,5", px_b, py_b); else n_pass++;
      end
      if (t == 480) begin
        n_checks++; if ({ls_b, fs_b} !== 2'b11) $display("FAIL b_wrap_strobes: got %b want 11", {ls_b, fs_b}); else n_pass++;
        n_checks++; if ({px_b, py_b} !== 22'd0) $display("FAIL b_wrap_coord: got %0d,%0d want 0,0", px_b, py_b); else n_pass++;
      end
    end
    n_checks++; if (vf !== 339) $display("FAIL b_vsync_start: got %0d want 339", vf); else n_pass++;
    n_checks++; if (vr - vf !== 96) $display("FAIL b_vsync_width: got %0d want 96", vr - vf); else n_pass++;
    n_checks++; if (hf !== 39) $display("FAIL b_hsync_start: got %0d want 39", hf); else n_pass++;
    n_checks++; if (hr - hf !== 6) $display("FAIL b_hsync_width: got %0d want 6", hr - hf); else n_pass++;
    n_checks++; if (fs2 !== 480) $display("FAIL b_frame_period: got %0d want 480", fs2); else n_pass++;
    n_checks++; if (reqs !== 96) $display("FAIL b_req_per_frame: got %0d want 96", reqs); else n_pass++;
    n_checks++; if (lss !== 10) $display("FAIL b_lines_per_frame: got %0d want 10", lss); else n_pass++;
  endtask

  task automatic test_pattern();
    pat_b = 1'b0;
    release_b();
    wait_b(100);
    pat_b = 1'b1;
    wait_b(165);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd1, 3'd5, 3'd3}) $display("FAIL pat_midframe: got %h want %h", {vr_b, vg_b, vb_b}, {3'd1, 3'd5, 3'd3}); else n_pass++;
    wait_b(483);
    n_checks++; if ({vr_b, vg_b, vb_b} !== 9'd0) $display("FAIL pat_bar0: got %h want 0", {vr_b, vg_b, vb_b}); else n_pass++;
    wait_b(487);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd0, 3'd0, 3'd7}) $display("FAIL pat_bar1: got %h want %h", {vr_b, vg_b, vb_b}, {3'd0, 3'd0, 3'd7}); else n_pass++;
    wait_b(493);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd0, 3'd7, 3'd0}) $display("FAIL pat_bar2: got %h want %h", {vr_b, vg_b, vb_b}, {3'd0, 3'd7, 3'd0}); else n_pass++;
    wait_b(501);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd7, 3'd0, 3'd0}) $display("FAIL pat_bar4: got %h want %h", {vr_b, vg_b, vb_b}, {3'd7, 3'd0, 3'd0}); else n_pass++;
    wait_b(512);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd7, 3'd7, 3'd7}) $display("FAIL pat_bar7: got %h want %h", {vr_b, vg_b, vb_b}, {3'd7, 3'd7, 3'd7}); else n_pass++;
    wait_b(515);
    n_checks++; if ({vr_b, vg_b, vb_b} !== 9'd0) $display("FAIL pat_blank: got %h want 0", {vr_b, vg_b, vb_b}); else n_pass++;
    pat_b = 1'b0;
    wait_b(535);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd0, 3'd0, 3'd7}) $display("FAIL pat_held: got %h want %h", {vr_b, vg_b, vb_b}, {3'd0, 3'd0, 3'd7}); else n_pass++;
    wait_b(967);
    n_checks++; if ({vr_b, vg_b, vb_b} !== {3'd2, 3'd5, 3'd3}) $display("FAIL pat_off: got %h want %h", {vr_b, vg_b, vb_b}, {3'd2, 3'd5, 3'd3}); else n_pass++;
  endtask

  task automatic test_midreset();
    release_b();
    wait_b(166);
    n_checks++; if ({px_b, py_b, req_b} !== {11'd11, 11'd3, 1'b1}) $display("FAIL mr_before: got %0d,%0d,%b want 11,3,1", px_b, py_b, req_b); else n_pass++;
    n_checks++; if ({vr_b, vg_b} !== {3'd1, 3'd5}) $display("FAIL mr_colour_before: got %h want %h", {vr_b, vg_b}, {3'd1, 3'd5}); else n_pass++;
    rst_b = 1'b1;
    tick();
    n_checks++; if ({px_b, py_b} !== 22'd0) $display("FAIL mr_coord: got %0d,%0d want 0,0", px_b, py_b); else n_pass++;
    n_checks++; if ({req_b, ls_b, fs_b} !== 3'b000) $display("FAIL mr_strobes: got %b want 000", {req_b, ls_b, fs_b}); else n_pass++;
    n_checks++; if ({vr_b, vg_b, vb_b, hs_b, vs_b} !== {9'd0, 2'b11}) $display("FAIL mr_outputs: got %h want %h", {vr_b, vg_b, vb_b, hs_b, vs_b}, {9'd0, 2'b11}); else n_pass++;
    rst_b = 1'b0;
    tick();
    t_b = 0;
    n_checks++; if ({req_b, ls_b, fs_b} !== 3'b111) $display("FAIL mr_restart_strobes: got %b want 111", {req_b, ls_b, fs_b}); else n_pass++;
    n_checks++; if ({px_b, py_b} !== 22'd0) $display("FAIL mr_restart_coord: got %0d,%0d want 0,0", px_b, py_b); else n_pass++;
    wait_b(1);
    n_checks++; if (vg_b !== 3'd0) $display("FAIL mr_discard1: got %0d want 0", vg_b); else n_pass++;
    wait_b(2);
    n_checks++; if (vg_b !== 3'd0) $display("FAIL mr_discard2: got %0d want 0", vg_b); else n_pass++;
    wait_b(5);
    n_checks++; if ({vr_b, vg_b} !== {3'd1, 3'd5}) $display("FAIL mr_resume: got %h want %h", {vr_b, vg_b}, {3'd1, 3'd5}); else n_pass++;
  endtask

  task automatic test_sweep();
    int hr1 = -1, hf1 = -1, hr2 = -1, vr1 = -1, vf1 = -1, fs2 = -1, reqs = 0;
    logic prev_hs, prev_vs;
    rst_c = 1'b1;
    repeat (5) tick();
    n_checks++; if ({hs_c, vs_c} !== 2'b00) $display("FAIL c_rst_sync: got %b want 00", {hs_c, vs_c}); else n_pass++;
    rst_c = 1'b0;
    prev_hs = 1'b0;
    prev_vs = 1'b0;
    for (int t = 0; t <= 33800; t++) begin
      tick();
      if (t < 1056 && req_c) reqs++;
      if (t > 0 && fs_c && fs2 < 0) fs2 = t;
      if (!prev_hs && hs_c) begin
        if (hr1 < 0) hr1 = t;
        else if (hr2 < 0) hr2 = t;
      end
      if (prev_hs && !hs_c && hf1 < 0) hf1 = t;
      if (!prev_vs && vs_c && vr1 < 0) vr1 = t;
      if (prev_vs && !vs_c && vf1 < 0) vf1 = t;
      prev_hs = hs_c;
      prev_vs = vs_c;
      if (t == 799) begin
        n_checks++; if ({req_c, px_c} !== {1'b1, 11'd799}) $display("FAIL c_req_end: got %b,%0d want 1,799", req_c, px_c); else n_pass++;
      end
      if (t == 800) begin
        n_checks++; if (req_c !== 1'b0) $display("FAIL c_req_blank: got %b want 0", req_c); else n_pass++;
      end
      if (t == 33792) begin
        n_checks++; if (ls_c !== 1'b1) $display("FAIL c_frame_line: got %b want 1", ls_c); else n_pass++;
      end
    end
    n_checks++; if (reqs !== 800) $display("FAIL c_req_per_line: got %0d want 800", reqs); else n_pass++;
    n_checks++; if (hr1 !== 842) $display("FAIL c_hsync_start: got %0d want 842", hr1); else n_pass++;
    n_checks++; if (hf1 - hr1 !== 128) $display("FAIL c_hsync_width: got %0d want 128", hf1 - hr1); else n_pass++;
    n_checks++; if (hr2 - hr1 !== 1056) $display("FAIL c_hsync_period: got %0d want 1056", hr2 - hr1); else n_pass++;
    n_checks++; if (vr1 !== 5282) $display("FAIL c_vsync_start: got %0d want 5282", vr1); else n_pass++;
    n_checks++; if (vf1 - vr1 !== 4224) $display("FAIL c_vsync_width: got %0d want 4224", vf1 - vr1); else n_pass++;
    n_checks++; if (fs2 !== 33792) $display("FAIL c_frame_period: got %0d want 33792", fs2); else n_pass++;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    pat_a = 1'b0; pat_b = 1'b0; pat_c = 1'b0;
    r_a = 3'd5; g_a = 3'd2; b_a = 3'd1;
    g_b = 3'd5; b_b = 3'd3;
    r_c = 3'd0; g_c = 3'd0; b_c = 3'd0;
    test_reset();
    test_default_line();
    test_latency();
    test_frame_small();
    test_pattern();
    test_midreset();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel-fetch front end for the display path, driven from `CLOCK_50`. It produces H/V sync, blanking and colour outputs for any standard mode from a set of timing parameters, with per-pixel coordinates and a pixel-request strobe so upstream logic (framebuffer reader, neural-net result overlay) can fetch colour a fixed number of clocks ahead. A built-in colour-bar pattern mode is provided for bring-up.

## Interface
Parameters:
- `CLK_PER_PIX`, 2: clocks per pixel; must be 1 or greater. 50 MHz / 2 gives the 25 MHz 640x480 pixel clock.
- `H_ACTIVE`, 640: visible pixels per line. Must be divisible by 8.
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal front porch, sync and back porch, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical equivalents, in lines.
- `SYNC_POL`, 0: sync active level. 0 means active-low.
- `COLOR_W`, 3: bits per colour channel.
- `PIPE`, 2: colour-return latency in clocks, 1 to 8.

Ports:
- `CLOCK_50` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `pattern_en` in 1: selects colour-bar test pattern instead of `r_val`/`g_val`/`b_val`.
- `r_val`, `g_val`, `b_val` in COLOR_W each: pixel colour returned by the requester.
- `pix_x` out 11: active-area column of the current pixel.
- `pix_y` out 11: active-area row of the current pixel.
- `pix_req` out 1: one-clock pulse at the start of each active pixel.
- `line_start` out 1: one-clock pulse at the start of each line.
- `frame_start` out 1: one-clock pulse at the start of each frame.
- `VGA_R`, `VGA_G`, `VGA_B` out COLOR_W each: colour to the DAC.
- `VGA_H_SYNC` out 1, `VGA_V_SYNC` out 1: sync outputs.

## Operation
- **Prescaler.** `ce_cnt` counts 0..CLK_PER_PIX-1 and wraps. A pixel advance occurs on the wrap.
- **Horizontal counter.** `h_cnt` counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. It advances on each pixel advance and wraps to 0.
- **Vertical counter.** `v_cnt` counts 0..V_TOTAL-1, defined the same way. It advances only when `h_cnt` wraps.
- **Line and frame order:** active, front porch, sync, back porch.
- **Active region:** h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- **H sync** is asserted (level SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Otherwise it sits at ~SYNC_POL.
- **V sync** follows the same rule using v_cnt.
- **Coordinates.** `pix_x`/`pix_y` equal h_cnt/v_cnt while active and are held for all CLK_PER_PIX clocks of the pixel. During blanking they freeze at their last active value.
- **Strobes:**
  - `pix_req` is high on the first clock (ce_cnt==0) of each active pixel.
  - `line_start` is high on the first clock of h_cnt==0 on every line, including blank lines.
  - `frame_start` is high on the first clock of h_cnt==0, v_cnt==0.
- **Colour return.**
  - The requester must present colour for the pixel at the edge PIPE clocks after the edge that raised `pix_req`.
  - The block registers the colour at that edge and holds it until the next sample.
  - Colour outputs are forced to 0 whenever the delayed active flag is low.
- **Sync alignment.** Sync and active flags pass through a PIPE-deep delay line, so sync/blank edges line up with the colour stream.
- **Pattern mode.**
  - `pattern_en` is sampled only at `frame_start`, so the selection never changes mid-frame.
  - When selected, the bar index b = pix_x / (H_ACTIVE/8). Compute it with a bar counter, not a divider.
  - Output colour: R = {COLOR_W{b[2]}}, G = {COLOR_W{b[1]}}, B = {COLOR_W{b[0]}}. Bar 0 is black and bar 7 is white.
- **Widths.** All counters are 11-bit, so the parameters must keep H_TOTAL and V_TOTAL ≤ 2047.

## Timing
- **During reset:**
  - All counters, delay lines and the registered pattern select are 0.
  - `pix_x`=0, `pix_y`=0.
  - `pix_req`, `line_start`, `frame_start` = 0.
  - `VGA_R/G/B` = 0.
  - `VGA_H_SYNC`, `VGA_V_SYNC` = ~SYNC_POL.
- **Leaving reset.** The first edge that samples `reset`=0 starts pixel (0,0). `pix_req`, `line_start` and `frame_start` are high during the clock that follows that edge.
- **Reset mid-frame.** Takes effect at the next edge and overrides everything. Pipelined colour is discarded and the raster restarts at (0,0).
- **Output latency.** `VGA_*` lag `pix_req` by PIPE clocks. Each colour value is held for CLK_PER_PIX clocks.
- **Strobe spacing.**
  - `pix_req` pulses every CLK_PER_PIX clocks across the active line.
  - `line_start` pulses every H_TOTAL*CLK_PER_PIX clocks.
  - `frame_start` pulses every H_TOTAL*V_TOTAL*CLK_PER_PIX clocks. With default parameters that is 840000 clocks.
- **CLK_PER_PIX=1.** The prescaler is constant and `pix_req` is high for the whole active line.
- **Simultaneous wrap.** At h_cnt wrap on v_cnt=V_TOTAL-1, both counters go to 0 on the same edge and `frame_start` coincides with `line_start`.

## Test plan
- **Reset and first frame.** Hold reset 5 clocks, then release.
  - During reset the syncs read 1, colour reads 0 and all strobes read 0.
  - One clock after the release edge, `frame_start`, `line_start` and `pix_req` are all 1 with `pix_x`=0 and `pix_y`=0.
- **Default 640x480 sync timing.**
  - `VGA_H_SYNC` is low for 192 clocks with a period of 1600 clocks.
  - `VGA_V_SYNC` is low for 3200 clocks with a period of 840000 clocks.
  - Exactly 640×480 `pix_req` pulses occur per frame.
- **Latency check.** Set PIPE=3 and make the requester return r_val=pix_x[2:0] three clocks after `pix_req`.
  - `VGA_R` steps 0,1,..,7 in 2-clock runs, starting 3 clocks after the first `pix_req`.
  - `VGA_R` is 0 throughout blanking.
- **Pattern mode.** Assert `pattern_en` mid-frame.
  - The output is unchanged until the next `frame_start`.
  - From then, `pix_x` 0–79 gives 000/000/000, 80–159 gives B=111, and 560–639 gives 111/111/111.
- **Reset mid-line.** Assert reset at pixel (300,100) for 1 clock.
  - The next clock shows reset values.
  - After release the raster restarts at (0,0) with `frame_start`.
- **Parameter sweep.** CLK_PER_PIX=1, SYNC_POL=1, 800x600 timing (40/128/88, 1/4/23).
  - Sync pulses are active-high, 128 and 4×1056 clocks wide.
  - The frame period is 1056×628 clocks.
